// File: rtl/picorv32_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : picorv32_mem_responder
// Brief    : picorv32 native-bus memory slave: word RAM, fixed wait states,
//            byte-strobe writes and sticky error flags.
// Revision : 1.0
// ============================================================================
module picorv32_mem_responder #(
  parameter int          ADDR_WIDTH  = 10,
  parameter logic [31:0] MEM_BASE    = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 2,
  parameter              INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic [1:0]  err
);

  localparam int          C_DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [32:0] C_SPAN_M1 = (33'd4 << ADDR_WIDTH) - 33'd1;
  localparam logic [3:0]  C_WAIT    = 4'(WAIT_CYCLES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  err_q, err_d;

  logic [31:0] ram [0:C_DEPTH-1];

  logic                  w_enter_resp;
  logic                  w_abort;
  logic [31:0]           w_req_addr;
  logic [31:0]           w_req_wdata;
  logic [3:0]            w_req_wstrb;
  logic                  w_in_range;
  logic                  w_is_write;
  logic                  w_ram_we;
  logic [ADDR_WIDTH-1:0] w_index;
  logic                  w_unused;

  // With zero wait states the request is consumed on the capture edge, so
  // decode straight from the bus in IDLE and from the captured copy otherwise.
  always_comb begin
    w_req_addr  = (state_q == S_IDLE) ? mem_addr  : addr_q;
    w_req_wdata = (state_q == S_IDLE) ? mem_wdata : wdata_q;
    w_req_wstrb = (state_q == S_IDLE) ? mem_wstrb : wstrb_q;
  end

  assign w_in_range   = ((w_req_addr & ~C_SPAN_M1[31:0]) == MEM_BASE) &&
                        (w_req_addr[1:0] == 2'b00);
  assign w_index      = w_req_addr[ADDR_WIDTH+1:2];
  assign w_is_write   = |w_req_wstrb;
  assign w_enter_resp = mem_valid &&
                        (((state_q == S_IDLE) && (C_WAIT == 4'd0)) ||
                         ((state_q == S_WAIT) && (cnt_q <= 4'd1)));
  assign w_abort      = (state_q == S_WAIT) && !mem_valid;
  assign w_ram_we     = resetn && w_enter_resp && w_in_range && w_is_write;
  assign w_unused     = mem_instr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (mem_valid) begin
          state_d = (C_WAIT == 4'd0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!mem_valid) begin
          state_d = S_IDLE;
        end else if (cnt_q <= 4'd1) begin
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_ready = (state_q == S_RESP);
    mem_rdata = rdata_q;
    err       = err_q;
  end

  always_comb begin
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = 32'h0000_0000;
    err_d   = err_q;
    if ((state_q == S_IDLE) && mem_valid) begin
      cnt_d   = C_WAIT;
      addr_d  = mem_addr;
      wdata_d = mem_wdata;
      wstrb_d = mem_wstrb;
    end else if (state_q == S_WAIT) begin
      cnt_d = cnt_q - 4'd1;
    end else if (state_q == S_RESP) begin
      cnt_d = 4'd0;
    end
    if (w_enter_resp) begin
      if (!w_in_range) begin
        err_d[0] = 1'b1;
      end else if (!w_is_write) begin
        rdata_d = ram[w_index];
      end
    end
    if (w_abort) begin
      err_d[1] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q   <= 4'd0;
      addr_q  <= 32'h0000_0000;
      wdata_q <= 32'h0000_0000;
      wstrb_q <= 4'h0;
      rdata_q <= 32'h0000_0000;
      err_q   <= 2'b00;
    end else begin
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // RAM contents survive reset by design; only the write enable sees resetn.
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_req_wstrb[i]) begin
          ram[w_index][8*i +: 8] <= w_req_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_picorv32_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_picorv32_mem_responder
// Brief    : Scoreboard bench for picorv32_mem_responder (2 and 0 wait states).
// Revision : 1.0
// ============================================================================
module tb_picorv32_mem_responder;

  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  err;
  } exp_t;

  logic clk = 1'b0;
  logic rn  = 1'b1;

  logic [1:0]       v   = '0;
  logic [1:0]       ins = '0;
  logic [1:0][31:0] a;
  logic [1:0][31:0] wd;
  logic [1:0][3:0]  ws;
  logic [1:0]       rdy;
  logic [1:0][31:0] rd;
  logic [1:0][1:0]  er;

  logic [1:0][1:0]  exp_err = '0;
  logic [1:0]       prev_rdy = '0;
  int               rcount [2];
  exp_t             qa[$];
  exp_t             qb[$];
  int               total = 0;
  int               pass  = 0;

  always #5 clk = ~clk;

  picorv32_mem_responder #(
    .ADDR_WIDTH (10),
    .MEM_BASE   (32'h0000_0000),
    .WAIT_CYCLES(2),
    .INIT_FILE  ("")
  ) u_dut_w2 (
    .clk      (clk),
    .resetn   (rn),
    .mem_valid(v[0]),
    .mem_instr(ins[0]),
    .mem_addr (a[0]),
    .mem_wdata(wd[0]),
    .mem_wstrb(ws[0]),
    .mem_ready(rdy[0]),
    .mem_rdata(rd[0]),
    .err      (er[0])
  );

  picorv32_mem_responder #(
    .ADDR_WIDTH (10),
    .MEM_BASE   (32'h0000_0000),
    .WAIT_CYCLES(0),
    .INIT_FILE  ("")
  ) u_dut_w0 (
    .clk      (clk),
    .resetn   (rn),
    .mem_valid(v[1]),
    .mem_instr(ins[1]),
    .mem_addr (a[1]),
    .mem_wdata(wd[1]),
    .mem_wstrb(ws[1]),
    .mem_ready(rdy[1]),
    .mem_rdata(rd[1]),
    .err      (er[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act === expv) pass++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endtask

  task automatic push(input int d, input logic [31:0] rdata);
    exp_t e;
    e.rdata = rdata;
    e.err   = exp_err[d];
    if (d == 0) qa.push_back(e);
    else qb.push_back(e);
  endtask

  // Monitor: every response pops the oldest expectation for that instance.
  task automatic mon(input int d);
    exp_t e;
    if (rdy[d] === 1'b1) begin
      rcount[d]++;
      total++;
      if ((d == 0 && qa.size() == 0) || (d == 1 && qb.size() == 0)) begin
        $display("FAIL unexpected_ready dut%0d: mem_ready=1 expected no response", d);
      end else begin
        if (d == 0) e = qa.pop_front();
        else e = qb.pop_front();
        if (rd[d] === e.rdata && er[d] === e.err) pass++;
        else $display("FAIL response dut%0d: rdata=%h err=%b expected rdata=%h err=%b",
                      d, rd[d], er[d], e.rdata, e.err);
      end
      if (prev_rdy[d] === 1'b1) begin
        total++;
        $display("FAIL ready_twice dut%0d: mem_ready high two cycles, expected one", d);
      end
    end else if (rdy[d] === 1'b0 && rd[d] !== 32'h0) begin
      total++;
      $display("FAIL rdata_idle dut%0d: rdata=%h expected 00000000", d, rd[d]);
    end
    prev_rdy[d] = rdy[d];
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  // Issue one request at a negedge; scramble the bus while waiting so only
  // the captured request can produce the expected answer.
  task automatic req(input int d, input logic [31:0] ad, input logic [31:0] wdt,
                     input logic [3:0] st, input logic [31:0] exp_rd, input int lat);
    int n;
    push(d, exp_rd);
    v[d]  = 1'b1;
    a[d]  = ad;
    wd[d] = wdt;
    ws[d] = st;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (rdy[d] !== 1'b1) begin
        a[d]  = 32'hFFFF_FFFC;
        wd[d] = ~wdt;
        ws[d] = (st == 4'h0) ? 4'hF : 4'h0;
      end
    end while (rdy[d] !== 1'b1 && n < 20);
    chk($sformatf("latency dut%0d addr %h", d, ad), n, lat);
    @(negedge clk);
    v[d] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt_before;
    a  = '0;
    wd = '0;
    ws = '0;
    rcount[0] = 0;
    rcount[1] = 0;
    #1 rn = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_ready dut%0d", d), {31'd0, rdy[d]}, 32'd0);
      chk($sformatf("reset_rdata dut%0d", d), rd[d], 32'd0);
      chk($sformatf("reset_err dut%0d", d), {30'd0, er[d]}, 32'd0);
    end
    rn = 1'b1;
    @(negedge clk);

    // Zero wait states: back-to-back reads with valid held across the ready edge.
    req(1, 32'h0, 32'hA5A5_0000, 4'hF, 32'h0, 1);
    req(1, 32'h4, 32'h0000_5A5A, 4'hF, 32'h0, 1);
    push(1, 32'hA5A5_0000);
    push(1, 32'h0000_5A5A);
    v[1] = 1'b1; a[1] = 32'h0; ws[1] = 4'h0;
    @(negedge clk);
    chk("b2b_ready_1", {31'd0, rdy[1]}, 32'd1);
    a[1] = 32'h4;
    @(negedge clk);
    chk("b2b_gap", {31'd0, rdy[1]}, 32'd0);
    @(negedge clk);
    chk("b2b_ready_2", {31'd0, rdy[1]}, 32'd1);
    v[1] = 1'b0;
    @(negedge clk);
    chk("b2b_no_dup", {31'd0, rdy[1]}, 32'd0);

    // Two wait states: full write then read-back.
    req(0, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 3);
    req(0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 3);
    // Partial strobes.
    req(0, 32'h20, 32'h1122_3344, 4'hF, 32'h0, 3);
    req(0, 32'h20, 32'hAABB_CCDD, 4'b0101, 32'h0, 3);
    req(0, 32'h20, 32'h0, 4'h0, 32'h11BB_33DD, 3);
    // Out-of-range and misaligned accesses.
    req(0, 32'h0, 32'hCAFE_F00D, 4'hF, 32'h0, 3);
    exp_err[0][0] = 1'b1;
    req(0, 32'h1000, 32'h0, 4'h0, 32'h0, 3);
    req(0, 32'h6, 32'h0, 4'h0, 32'h0, 3);
    req(0, 32'h1000, 32'h1234_5678, 4'hF, 32'h0, 3);
    req(0, 32'h0, 32'h0, 4'h0, 32'hCAFE_F00D, 3);

    // Abort during WAIT.
    req(0, 32'h40, 32'h0102_0304, 4'hF, 32'h0, 3);
    cnt_before = rcount[0];
    v[0] = 1'b1; a[0] = 32'h40; wd[0] = 32'h5555_5555; ws[0] = 4'hF;
    @(negedge clk);
    v[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_no_ready", rcount[0], cnt_before);
    exp_err[0][1] = 1'b1;
    req(0, 32'h40, 32'h0, 4'h0, 32'h0102_0304, 3);

    // Asynchronous reset in the middle of a write's WAIT phase.
    req(0, 32'h30, 32'h0BAD_F00D, 4'hF, 32'h0, 3);
    v[0] = 1'b1; a[0] = 32'h30; wd[0] = 32'hFFFF_FFFF; ws[0] = 4'hF;
    @(negedge clk);
    rn = 1'b0;
    #1;
    chk("async_rst_ready", {31'd0, rdy[0]}, 32'd0);
    chk("async_rst_err", {30'd0, er[0]}, 32'd0);
    chk("async_rst_rdata", rd[0], 32'd0);
    v[0] = 1'b0;
    repeat (2) @(negedge clk);
    rn = 1'b1;
    exp_err = '0;
    @(negedge clk);
    req(0, 32'h30, 32'h0, 4'h0, 32'h0BAD_F00D, 3);

    repeat (3) @(negedge clk);
    chk("queue_empty_dut0", qa.size(), 32'd0);
    chk("queue_empty_dut1", qb.size(), 32'd0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
`default_nettype wire
